// File: rtl/tty_writer.sv
// Glass-TTY character writer: turns an ASCII stream into framebuffer RAM writes on port B,
// tracking a cursor and handling CR/LF/BS/FF, line wrap and page scroll.
module tty_writer #(
    parameter int          ROWS  = 32,
    parameter logic [7:0]  BLANK = 8'h20
) (
    input  logic        clk_data,
    input  logic        irstn,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [10:0] addrb,
    output logic [63:0] dinb,
    output logic [7:0]  web,
    output logic        enb,
    input  logic [63:0] doutb,
    output logic        busy,
    output logic [5:0]  cursor_row,
    output logic [6:0]  cursor_col
);

    localparam logic [10:0] PAGE_LAST     = 11'(16 * ROWS - 1);
    localparam logic [10:0] LAST_ROW_BASE = 11'(16 * (ROWS - 1));
    localparam logic [10:0] SCR_LAST_PAIR = 11'(16 * ROWS - 2);
    localparam logic [5:0]  LAST_ROW      = 6'(ROWS - 1);

    typedef enum logic [2:0] {IDLE, PUT, SCR_RD, SCR_WR, CLR} state_t;

    state_t      state, state_n;
    logic [10:0] w, w_n, clr_hi, clr_hi_n;
    logic        ph, ph_n, newline;
    logic [5:0]  row_n;
    logic [6:0]  col_n;
    logic        in_ready_n, busy_n, enb_n;
    logic [10:0] addrb_n;
    logic [63:0] dinb_n;
    logic [7:0]  web_n;

    function automatic logic [10:0] cell_word(input logic [5:0] r, input logic [6:0] c);
        return {1'b0, r, c[6:3]};
    endfunction

    always_ff @(posedge clk_data) begin
        if (!irstn) begin
            state      <= CLR;
            w          <= '0;
            clr_hi     <= PAGE_LAST;
            ph         <= 1'b0;
            cursor_row <= '0;
            cursor_col <= '0;
            in_ready   <= 1'b0;
            busy       <= 1'b1;
            enb        <= 1'b0;
            web        <= '0;
            addrb      <= '0;
            dinb       <= '0;
        end else begin
            state      <= state_n;
            w          <= w_n;
            clr_hi     <= clr_hi_n;
            ph         <= ph_n;
            cursor_row <= row_n;
            cursor_col <= col_n;
            in_ready   <= in_ready_n;
            busy       <= busy_n;
            enb        <= enb_n;
            web        <= web_n;
            addrb      <= addrb_n;
            dinb       <= dinb_n;
        end
    end

    // Outputs are registered from the current state, so each state's port access
    // appears in the following cycle.
    always_comb begin
        state_n    = state;
        w_n        = w;
        clr_hi_n   = clr_hi;
        ph_n       = ph;
        row_n      = cursor_row;
        col_n      = cursor_col;
        in_ready_n = 1'b0;
        busy_n     = 1'b0;
        enb_n      = 1'b0;
        web_n      = '0;
        addrb_n    = addrb;
        dinb_n     = dinb;
        newline    = 1'b0;

        case (state)
            IDLE: begin
                in_ready_n = 1'b1;
                if (in_valid && in_ready) begin
                    if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                        state_n    = PUT;
                        in_ready_n = 1'b0;
                        enb_n      = 1'b1;
                        web_n      = 8'b1 << cursor_col[2:0];
                        addrb_n    = cell_word(cursor_row, cursor_col);
                        dinb_n     = {8{in_data}};
                    end else begin
                        case (in_data)
                            8'h0D: col_n = '0;
                            8'h0A: begin
                                col_n   = '0;
                                newline = 1'b1;
                            end
                            8'h08: if (cursor_col != 7'd0) col_n = cursor_col - 7'd1;
                            8'h0C: begin
                                state_n    = CLR;
                                w_n        = '0;
                                clr_hi_n   = PAGE_LAST;
                                row_n      = '0;
                                col_n      = '0;
                                in_ready_n = 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            PUT: begin
                if (cursor_col == 7'd127) begin
                    col_n   = '0;
                    newline = 1'b1;
                end else begin
                    col_n      = cursor_col + 7'd1;
                    state_n    = IDLE;
                    in_ready_n = 1'b1;
                end
            end
            // Two reads then two writes: each write takes doutb captured the cycle
            // after its read, so the port stays busy every cycle.
            SCR_RD: begin
                busy_n  = 1'b1;
                enb_n   = 1'b1;
                addrb_n = w + 11'(ph);
                ph_n    = ~ph;
                if (ph) state_n = SCR_WR;
            end
            SCR_WR: begin
                busy_n  = 1'b1;
                enb_n   = 1'b1;
                web_n   = 8'hFF;
                addrb_n = w + 11'(ph) - 11'd16;
                dinb_n  = doutb;
                ph_n    = ~ph;
                if (ph) begin
                    if (w == SCR_LAST_PAIR) begin
                        state_n  = CLR;
                        w_n      = LAST_ROW_BASE;
                        clr_hi_n = PAGE_LAST;
                    end else begin
                        state_n = SCR_RD;
                        w_n     = w + 11'd2;
                    end
                end
            end
            CLR: begin
                busy_n  = 1'b1;
                enb_n   = 1'b1;
                web_n   = 8'hFF;
                addrb_n = w;
                dinb_n  = {8{BLANK}};
                if (w == clr_hi) state_n = IDLE;
                else             w_n = w + 11'd1;
            end
            default: state_n = CLR;
        endcase

        if (newline) begin
            if (cursor_row < LAST_ROW) begin
                row_n      = cursor_row + 6'd1;
                state_n    = IDLE;
                in_ready_n = 1'b1;
            end else begin
                state_n    = SCR_RD;
                w_n        = 11'd16;
                ph_n       = 1'b0;
                in_ready_n = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tty_writer.sv
// Directed bench for tty_writer with a behavioural port-B RAM model.
module tb_tty_writer;

    localparam logic [63:0] BW = {8{8'h20}};

    logic        clk_data = 1'b0;
    logic        irstn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [10:0] addrb;
    logic [63:0] dinb;
    logic [7:0]  web;
    logic        enb;
    logic [63:0] doutb;
    logic        busy;
    logic [5:0]  cursor_row;
    logic [6:0]  cursor_col;

    int n_cmp = 0;
    int n_bad = 0;

    tty_writer #(.ROWS(32), .BLANK(8'h20)) dut (
        .clk_data  (clk_data),
        .irstn     (irstn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .addrb     (addrb),
        .dinb      (dinb),
        .web       (web),
        .enb       (enb),
        .doutb     (doutb),
        .busy      (busy),
        .cursor_row(cursor_row),
        .cursor_col(cursor_col)
    );

    always #5 clk_data = ~clk_data;

    // Port-B RAM: read data registered, valid the cycle after a read strobe.
    logic [63:0] mem [0:2047];
    logic [63:0] bmask;
    always @(posedge clk_data) begin
        if (enb) begin
            if (web == 8'h00) begin
                doutb <= mem[addrb];
            end else begin
                for (int b = 0; b < 8; b++) bmask[b*8 +: 8] = {8{web[b]}};
                mem[addrb] <= (mem[addrb] & ~bmask) | (dinb & bmask);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_data);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 3000) begin
            step();
            t++;
        end
        if (!in_ready) chk("ready_timeout", {63'd0, in_ready}, 64'd1);
    endtask

    task automatic send(input logic [7:0] b);
        wait_ready();
        in_valid = 1'b1;
        in_data  = b;
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        int t = 0;
        int good = 0;
        while (!enb && t < 10) begin
            step();
            t++;
        end
        for (int i = 0; i < 512; i++) begin
            if (enb && web == 8'hFF && addrb == 11'(i) && dinb == BW) good++;
            step();
        end
        chk({tag, "_writes"}, 64'(good), 64'd512);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd1);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, {63'd0, in_ready}, 64'd0);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd1);
        chk({tag, "_enb"}, {63'd0, enb}, 64'd0);
        chk({tag, "_web"}, {56'd0, web}, 64'd0);
        chk({tag, "_addrb"}, {53'd0, addrb}, 64'd0);
        chk({tag, "_dinb"}, dinb, 64'd0);
        chk({tag, "_row"}, {58'd0, cursor_row}, 64'd0);
        chk({tag, "_col"}, {57'd0, cursor_col}, 64'd0);
    endtask

    initial begin
        int good;
        int cyc;
        int bcnt;
        irstn    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        step();
        step();
        check_reset_outputs("rst");

        irstn = 1'b1;
        step();
        chk("rst_first_enb", {63'd0, enb}, 64'd1);
        check_clear("init_clr");
        chk("init_row", {58'd0, cursor_row}, 64'd0);
        chk("init_col", {57'd0, cursor_col}, 64'd0);

        send(8'h41);
        chk("A_addr", {53'd0, addrb}, 64'd0);
        chk("A_web", {56'd0, web}, 64'h01);
        chk("A_dinb", dinb, {8{8'h41}});
        send(8'h42);
        chk("B_web", {56'd0, web}, 64'h02);
        chk("B_dinb", dinb, {8{8'h42}});
        wait_ready();
        chk("AB_col", {57'd0, cursor_col}, 64'd2);

        send(8'h0D);
        chk("cr_enb", {63'd0, enb}, 64'd0);
        chk("cr_col", {57'd0, cursor_col}, 64'd0);
        chk("cr_ready", {63'd0, in_ready}, 64'd1);
        send(8'h08);
        chk("bs0_col", {57'd0, cursor_col}, 64'd0);
        send(8'h01);
        chk("ign_enb", {63'd0, enb}, 64'd0);
        chk("ign_col", {57'd0, cursor_col}, 64'd0);

        for (int i = 0; i < 127; i++) send(8'h78);
        send(8'h79);
        chk("y_addr", {53'd0, addrb}, 64'd15);
        chk("y_web", {56'd0, web}, 64'h80);
        wait_ready();
        chk("wrap_row", {58'd0, cursor_row}, 64'd1);
        chk("wrap_col", {57'd0, cursor_col}, 64'd0);
        send(8'h7A);
        chk("z_addr", {53'd0, addrb}, 64'd16);
        chk("z_web", {56'd0, web}, 64'h01);
        wait_ready();
        chk("z_col", {57'd0, cursor_col}, 64'd1);

        send(8'h0D);
        for (int i = 0; i < 128; i++) send(8'h51);
        wait_ready();
        chk("Q_row", {58'd0, cursor_row}, 64'd2);
        send(8'h0A);
        chk("lf_row", {58'd0, cursor_row}, 64'd3);
        chk("lf_ready", {63'd0, in_ready}, 64'd1);
        for (int i = 0; i < 28; i++) send(8'h0A);
        wait_ready();
        chk("lf31_row", {58'd0, cursor_row}, 64'd31);

        send(8'h0A);
        cyc  = 0;
        bcnt = 0;
        while (!in_ready && cyc < 3000) begin
            if (busy) bcnt++;
            step();
            cyc++;
        end
        chk("scroll_busy", 64'(bcnt), 64'd1008);
        chk("scroll_row", {58'd0, cursor_row}, 64'd31);
        chk("scroll_col", {57'd0, cursor_col}, 64'd0);
        good = 0;
        for (int i = 0; i < 16; i++) if (mem[i] === {8{8'h51}}) good++;
        chk("scroll_row0", 64'(good), 64'd16);
        good = 0;
        for (int i = 16; i < 32; i++) if (mem[i] === BW) good++;
        chk("scroll_row1", 64'(good), 64'd16);
        good = 0;
        for (int i = 496; i < 512; i++) if (mem[i] === BW) good++;
        chk("scroll_last", 64'(good), 64'd16);

        send(8'h43);
        wait_ready();
        chk("C_col", {57'd0, cursor_col}, 64'd1);
        send(8'h08);
        chk("bs_enb", {63'd0, enb}, 64'd0);
        chk("bs_col", {57'd0, cursor_col}, 64'd0);
        send(8'h0D);
        chk("cr2_enb", {63'd0, enb}, 64'd0);
        send(8'h0C);
        check_clear("ff_clr");
        chk("ff_row", {58'd0, cursor_row}, 64'd0);
        chk("ff_col", {57'd0, cursor_col}, 64'd0);
        good = 0;
        for (int i = 0; i < 512; i++) if (mem[i] === BW) good++;
        chk("ff_mem", 64'(good), 64'd512);

        for (int i = 0; i < 32; i++) send(8'h0A);
        repeat (100) step();
        chk("mid_busy", {63'd0, busy}, 64'd1);
        irstn = 1'b0;
        step();
        check_reset_outputs("abort");
        irstn = 1'b1;
        step();
        chk("abort_first_enb", {63'd0, enb}, 64'd1);
        check_clear("abort_clr");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
